// File: rtl/jtframe_68kbus_arb_if.sv
// 68000 arbitration pins plus the DMA requester request/grant lines.
// The master modport is the arbiter; slave is the CPU/DMA side.
interface jtframe_68kbus_arb_if #(
    parameter int unsigned NREQ = 2
);
    logic            cpu_BRn;
    logic            cpu_BGACKn;
    logic            cpu_BGn;
    logic            cpu_ASn;
    logic            cpu_DTACKn;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            busy;

    modport master (
        output cpu_BRn, cpu_BGACKn, gnt, busy,
        input  cpu_BGn, cpu_ASn, cpu_DTACKn, req
    );

    modport slave (
        input  cpu_BRn, cpu_BGACKn, gnt, busy,
        output cpu_BGn, cpu_ASn, cpu_DTACKn, req
    );
endinterface

// File: rtl/jtframe_68kbus_arb.sv
// Round-robin 68000 BR/BG/BGACK arbiter for on-board DMA requesters.
// Define JTFRAME_68KARB_TIMEOUT_EN to limit each tenure to MAXHOLD cen cycles.
module jtframe_68kbus_arb #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned HOLDW   = 8,
    parameter int unsigned MAXHOLD = 64,
    parameter int unsigned CPUGAP  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cen,
    jtframe_68kbus_arb_if.master   bus
);
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {StIdle, StReq, StWait, StOwn, StSwitch, StRel} state_e;

    state_e          state_q, state_d;
    logic            brn_q, brn_d;
    logic            bgackn_q, bgackn_d;
    logic            busy_q;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [3:0]      gap_q, gap_d;

    logic [NREQ-1:0] req_hi, cand, win_oh;
    logic [PtrW-1:0] win_nxt;
    logic            found, any_req, own_req;

`ifdef JTFRAME_68KARB_TIMEOUT_EN
    logic [HOLDW-1:0] ten_q, ten_d, ten_inc;
    logic             other_req;
`else
    logic unused_cfg;
    assign unused_cfg = ^{HOLDW[0], MAXHOLD[0]};
`endif

    assign any_req = |bus.req;
    assign own_req = |(bus.req & gnt_q);

    // Pending requests at or above the pointer win first; otherwise wrap to the lowest.
    always_comb begin
        req_hi  = '0;
        win_oh  = '0;
        win_nxt = '0;
        found   = 1'b0;
        for (int j = 0; j < int'(NREQ); j++) begin
            req_hi[j] = bus.req[j] && (j >= int'(ptr_q));
        end
        cand = (|req_hi) ? req_hi : bus.req;
        for (int j = 0; j < int'(NREQ); j++) begin
            if (!found && cand[j]) begin
                found     = 1'b1;
                win_oh[j] = 1'b1;
                win_nxt   = (j == int'(NREQ) - 1) ? '0 : PtrW'(j + 1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        brn_d    = brn_q;
        bgackn_d = bgackn_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        gap_d    = gap_q;
`ifdef JTFRAME_68KARB_TIMEOUT_EN
        ten_d     = ten_q;
        ten_inc   = (&ten_q) ? ten_q : ten_q + 1'b1;
        other_req = |(bus.req & ~gnt_q);
`endif
        unique case (state_q)
            StIdle: begin
                if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
                if (any_req && gap_q == 4'd0) begin
                    brn_d   = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (!any_req) begin
                    brn_d   = 1'b1;
                    state_d = StIdle;
                end else if (!bus.cpu_BGn) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // Take the bus only once the CPU's current cycle has closed.
                if (bus.cpu_ASn && bus.cpu_DTACKn) begin
                    bgackn_d = 1'b0;
                    brn_d    = 1'b1;
                    if (any_req) begin
                        gnt_d   = win_oh;
                        ptr_d   = win_nxt;
                        state_d = StOwn;
`ifdef JTFRAME_68KARB_TIMEOUT_EN
                        ten_d   = '0;
`endif
                    end else begin
                        state_d = StRel;
                    end
                end
            end
            StOwn: begin
`ifdef JTFRAME_68KARB_TIMEOUT_EN
                ten_d = ten_inc;
`endif
                if (!own_req) begin
                    gnt_d   = '0;
                    state_d = StSwitch;
                end
`ifdef JTFRAME_68KARB_TIMEOUT_EN
                else if (ten_inc >= HOLDW'(MAXHOLD)) begin
                    gnt_d   = '0;
                    state_d = other_req ? StSwitch : StRel;
                end
`endif
            end
            StSwitch: begin
                if (any_req) begin
                    gnt_d   = win_oh;
                    ptr_d   = win_nxt;
                    state_d = StOwn;
`ifdef JTFRAME_68KARB_TIMEOUT_EN
                    ten_d   = '0;
`endif
                end else begin
                    state_d = StRel;
                end
            end
            StRel: begin
                bgackn_d = 1'b1;
                gap_d    = 4'(CPUGAP);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            brn_q    <= 1'b1;
            bgackn_q <= 1'b1;
            busy_q   <= 1'b0;
            gnt_q    <= '0;
            ptr_q    <= '0;
            gap_q    <= '0;
`ifdef JTFRAME_68KARB_TIMEOUT_EN
            ten_q    <= '0;
`endif
        end else if (cen) begin
            state_q  <= state_d;
            brn_q    <= brn_d;
            bgackn_q <= bgackn_d;
            busy_q   <= !bgackn_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            gap_q    <= gap_d;
`ifdef JTFRAME_68KARB_TIMEOUT_EN
            ten_q    <= ten_d;
`endif
        end
    end

    assign bus.cpu_BRn    = brn_q;
    assign bus.cpu_BGACKn = bgackn_q;
    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_jtframe_68kbus_arb.sv
// Directed bench for jtframe_68kbus_arb with a simple CPU model (BGn follows BRn).
// Build with JTFRAME_68KARB_TIMEOUT_EN defined to exercise the tenure limit.
module tb_jtframe_68kbus_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cen = 1'b1;
    logic cpu_auto = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    jtframe_68kbus_arb_if #(.NREQ(2)) bus ();

    jtframe_68kbus_arb #(
        .NREQ    (2),
        .HOLDW   (8),
        .MAXHOLD (8),
        .CPUGAP  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; sample 1 time unit later, then let the CPU model react.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cpu_auto) bus.cpu_BGn = bus.cpu_BRn;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        cen            = 1'b1;
        bus.req        = 2'b00;
        bus.cpu_ASn    = 1'b1;
        bus.cpu_DTACKn = 1'b1;
        bus.cpu_BGn    = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req        = 2'b00;
        bus.cpu_BGn    = 1'b1;
        bus.cpu_ASn    = 1'b1;
        bus.cpu_DTACKn = 1'b1;
        tick();
        tick();
        check("rst_brn",    32'(bus.cpu_BRn),    32'd1);
        check("rst_bgackn", 32'(bus.cpu_BGACKn), 32'd1);
        check("rst_gnt",    32'(bus.gnt),        32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        rst_n = 1'b1;

        // Single requester: grant at edge 2, release 3 edges after drop, CPU gap.
        bus.req = 2'b01;
        tick();
        check("t1_brn_e0", 32'(bus.cpu_BRn), 32'd0);
        tick();
        check("t1_gnt_e1", 32'(bus.gnt), 32'd0);
        check("t1_bgk_e1", 32'(bus.cpu_BGACKn), 32'd1);
        tick();
        check("t1_gnt_e2",  32'(bus.gnt),        32'd1);
        check("t1_bgk_e2",  32'(bus.cpu_BGACKn), 32'd0);
        check("t1_busy_e2", 32'(bus.busy),       32'd1);
        check("t1_brn_e2",  32'(bus.cpu_BRn),    32'd1);
        tick();
        check("t1_hold", 32'(bus.gnt), 32'd1);
        bus.req = 2'b00;
        tick();
        check("t1_drop_gnt", 32'(bus.gnt),        32'd0);
        check("t1_drop_bgk", 32'(bus.cpu_BGACKn), 32'd0);
        tick();
        check("t1_rel_bgk", 32'(bus.cpu_BGACKn), 32'd0);
        tick();
        check("t1_free_bgk",  32'(bus.cpu_BGACKn), 32'd1);
        check("t1_free_busy", 32'(bus.busy),       32'd0);
        bus.req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t1_gap_brn", 32'(bus.cpu_BRn), 32'd1);
        end
        tick();
        check("t1_gap_end", 32'(bus.cpu_BRn), 32'd0);

        // Two requesters: handover without releasing BGACKn.
        do_reset();
        bus.req = 2'b11;
        tick();
        tick();
        tick();
        check("t2_first", 32'(bus.gnt), 32'd1);
        bus.req = 2'b10;
        tick();
        check("t2_turn_gnt", 32'(bus.gnt),        32'd0);
        check("t2_turn_bgk", 32'(bus.cpu_BGACKn), 32'd0);
        tick();
        check("t2_second",   32'(bus.gnt),        32'd2);
        check("t2_sec_bgk",  32'(bus.cpu_BGACKn), 32'd0);

        // Reset mid-tenure, then cen=0 freezes everything.
        rst_n = 1'b0;
        tick();
        check("t6_brn",  32'(bus.cpu_BRn),    32'd1);
        check("t6_bgk",  32'(bus.cpu_BGACKn), 32'd1);
        check("t6_gnt",  32'(bus.gnt),        32'd0);
        check("t6_busy", 32'(bus.busy),       32'd0);
        rst_n   = 1'b1;
        cen     = 1'b0;
        bus.req = 2'b11;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t6_frz_brn", 32'(bus.cpu_BRn), 32'd1);
            check("t6_frz_gnt", 32'(bus.gnt),     32'd0);
        end
        cen = 1'b1;

        // CPU mid-cycle: no BGACKn until AS and DTACK are both high.
        do_reset();
        bus.cpu_ASn = 1'b0;
        bus.req     = 2'b01;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_as_bgk", 32'(bus.cpu_BGACKn), 32'd1);
            check("t3_as_gnt", 32'(bus.gnt),        32'd0);
        end
        bus.cpu_ASn    = 1'b1;
        bus.cpu_DTACKn = 1'b0;
        tick();
        check("t3_dtk_bgk", 32'(bus.cpu_BGACKn), 32'd1);
        bus.cpu_DTACKn = 1'b1;
        tick();
        check("t3_ok_bgk", 32'(bus.cpu_BGACKn), 32'd0);
        check("t3_ok_gnt", 32'(bus.gnt),        32'd1);

        // Request gone by the time the bus is free: take it with gnt=0, then release.
        do_reset();
        cpu_auto = 1'b0;
        bus.req  = 2'b01;
        tick();
        bus.cpu_BGn = 1'b0;
        tick();
        bus.req = 2'b00;
        tick();
        check("t7_bgk", 32'(bus.cpu_BGACKn), 32'd0);
        check("t7_gnt", 32'(bus.gnt),        32'd0);
        tick();
        check("t7_free", 32'(bus.cpu_BGACKn), 32'd1);

        // Withdrawal before BGn falls.
        do_reset();
        cpu_auto = 1'b0;
        bus.req  = 2'b10;
        tick();
        check("t4_brn_lo", 32'(bus.cpu_BRn), 32'd0);
        bus.req = 2'b00;
        tick();
        check("t4_brn_hi", 32'(bus.cpu_BRn), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_gnt", 32'(bus.gnt), 32'd0);
        end
        cpu_auto = 1'b1;

        // Both held: alternation under the tenure limit, otherwise permanent ownership.
        do_reset();
        bus.req = 2'b11;
        tick();
        tick();
        tick();
        check("t5_g0", 32'(bus.gnt), 32'd1);
`ifdef JTFRAME_68KARB_TIMEOUT_EN
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t5_own0", 32'(bus.gnt), 32'd1);
        end
        tick();
        check("t5_gap0", 32'(bus.gnt), 32'd0);
        tick();
        check("t5_g1", 32'(bus.gnt), 32'd2);
        for (int k = 0; k < 7; k++) begin
            tick();
            check("t5_own1", 32'(bus.gnt), 32'd2);
        end
        tick();
        check("t5_gap1", 32'(bus.gnt), 32'd0);
        tick();
        check("t5_g2", 32'(bus.gnt), 32'd1);
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            check("t5_perm_gnt", 32'(bus.gnt),        32'd1);
            check("t5_perm_bgk", 32'(bus.cpu_BGACKn), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/jtframe_68kbus_arb.md
# jtframe_68kbus_arb

Bus arbiter that shares the 68000 bus among several on-board DMA requesters (object, palette, blitter) using the full 68000 three-wire arbitration protocol (BR/BG/BGACK). It requests the bus from the CPU and waits for the CPU's current cycle to close. It then hands tenure to one requester at a time in round-robin order, hands over between requesters without returning the bus to the CPU, and guarantees the CPU a minimum window between DMA tenures. It sits between the CPU's arbitration pins and the DMA engines' bus-master muxes.

## Interface
- NREQ, 2, number of requesters (1..8)
- HOLDW, 8, width of tenure counter
- MAXHOLD, 64, maximum cen cycles one requester may own the bus (timeout build only; 1..2^HOLDW-1)
- CPUGAP, 4, minimum cen cycles with BRn high after a full release, before BRn may fall again (1..15)

- clk  in  1  system clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- cen  in  1  clock enable; all state and counters advance only on clk edges with cen=1
- cpu_BRn  out  1  bus request to 68000, active low
- cpu_BGACKn  out  1  bus grant acknowledge to 68000, active low
- cpu_BGn  in  1  bus grant from 68000, active low
- cpu_ASn  in  1  68000 address strobe
- cpu_DTACKn  in  1  data acknowledge on the CPU bus
- req  in  NREQ  per-requester bus request, level, held for the whole tenure
- gnt  out  NREQ  one-hot grant; requester drives the bus only while its bit is high
- busy  out  1  high while cpu_BGACKn is low

## Operation
- Reset values: cpu_BRn=1, cpu_BGACKn=1, gnt=0, busy=0, state=IDLE, round-robin pointer=0, tenure and gap counters=0.
- All outputs are registered.
- IDLE:
  - Gap counter counts down to 0.
  - When |req and gap==0: cpu_BRn<=0 and go to REQ.
- REQ:
  - If no req is pending: cpu_BRn<=1 and go to IDLE (withdrawal).
  - Else if cpu_BGn==0: go to WAIT.
- WAIT: when cpu_ASn==1 and cpu_DTACKn==1, in a single edge:
  - cpu_BGACKn<=0, cpu_BRn<=1.
  - Pick a winner and set its gnt bit.
  - Clear the tenure counter.
  - Go to OWN.
  - If no req is pending at this edge: take the bus with gnt=0 and go to REL.
- Winner selection: lowest-index pending req at or above pointer, wrapping modulo NREQ. On every grant, pointer<=winner+1 (mod NREQ).
- OWN:
  - Tenure counter increments per cen and saturates.
  - If the owner's req falls: gnt<=0 and go to SWITCH.
- SWITCH: one cen cycle with gnt=0 and BGACKn still low (bus turnaround). Then:
  - If another req is pending: grant the next winner, clear tenure, go to OWN.
  - Else: go to REL.
- REL: gnt=0 for one cen cycle. Then cpu_BGACKn<=1, busy<=0, gap<=CPUGAP, go to IDLE.
- A requester whose gnt falls while its req is still high has been preempted. It stays in the rotation and is re-granted later.
- busy mirrors !cpu_BGACKn.

## Timing
- With cen=1 every cycle, req rises before edge 0:
  - Edge 0: BRn=0.
  - Edge 1: BGn=0 is sampled.
  - Edge 2: BGACKn=0 and gnt valid, provided AS and DTACK are high.
- Minimum latency req→gnt is 3 cen edges.
- Owner-to-owner handover: 2 cen edges (req falls → gnt=0 at next edge → new gnt at following edge).
- Release: last req falls → BGACKn high 3 cen edges later. BRn stays high for at least CPUGAP cen cycles after that.
- cen=0 freezes all state, counters and outputs.
- Simultaneous owner req drop and timeout expiry: the drop takes priority (SWITCH).
- Reset asserted mid-tenure: all outputs return to reset values at that edge, with no handshaking. The DMA engine must tri-state on gnt=0.
- BGn rising while in WAIT (CPU retracted the grant) is ignored. The 68000 does not do this once BR is held.

## Configuration
- JTFRAME_68KARB_TIMEOUT_EN defined:
  - In OWN, when the tenure counter reaches MAXHOLD and any other req is pending: gnt<=0, go to SWITCH.
  - If no other req is pending, go to REL instead, so the CPU gets its gap.
- Not defined: tenure is unlimited and the tenure counter is not implemented. Preemption never occurs.

## Test plan
- Single requester, NREQ=2, BGn follows BRn after 1 cycle, AS/DTACK high: req[0] high → gnt=01 at edge 2. Drop req[0] → BGACKn=1 3 edges later, BRn held high for 4 cycles (CPUGAP=4).
- req=11 simultaneously from reset → gnt=01 first. Drop req[0] → one cycle gnt=00, then gnt=10. BGACKn stays low throughout.
- CPU mid-cycle: BGn low but ASn low for 5 cycles → BGACKn stays high until ASn and DTACKn are both high, then falls with gnt.
- Withdrawal: req[1] pulses 1 cycle → BRn falls, then returns high in REQ if BGn has not yet fallen. gnt never asserted.
- Timeout build, MAXHOLD=8, req=11 held → gnt alternates 01/10 every 8 owned cycles plus 1 gap cycle. Non-timeout build, same stimulus → gnt=01 permanently.
- rst_n low while gnt=10 → next edge: BRn=1, BGACKn=1, gnt=00, busy=0. Then cen=0 for 10 cycles with req high → no output change.
